// File: rtl/pong_duel_engine.sv
// Two-player Pong engine: paddles, ball physics, scoring and game sequencing,
// plus a registered pixel renderer driven by the VGA sync counters.
module pong_duel_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int L_PAD_X     = 32,
    parameter int R_PAD_X     = 600,
    parameter int PAD_W       = 4,
    parameter int PAD_H       = 72,
    parameter int PAD_V       = 4,
    parameter int BALL_V      = 2,
    parameter int SCORE_W     = 4,
    parameter int MAX_SCORE   = 9,
    parameter int MISS_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [1:0]         btn_l,
    input  logic [1:0]         btn_r,
    input  logic               serve,
    output logic [2:0]         graph_rgb,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over
);
    localparam int CNT_W = (MISS_FRAMES > 2) ? $clog2(MISS_FRAMES) : 1;

    localparam logic [9:0] TICK_Y     = 10'(V_ACTIVE + 1);
    localparam logic [9:0] PAD_MAX    = 10'(V_ACTIVE - PAD_H);
    localparam logic [9:0] PAD_CTR    = 10'((V_ACTIVE - PAD_H) / 2);
    localparam logic [9:0] PAD_STEP   = 10'(PAD_V);
    localparam logic [9:0] PAD_H_M1   = 10'(PAD_H - 1);
    localparam logic [9:0] BALL_X0    = 10'(H_ACTIVE / 2 - 4);
    localparam logic [9:0] BALL_Y0    = 10'(V_ACTIVE / 2 - 4);
    localparam logic [9:0] BV         = 10'(BALL_V);
    localparam logic [9:0] X_MISS_R   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_BOT      = 10'(V_ACTIVE - 1 - BALL_V);
    localparam logic [9:0] L_X0       = 10'(L_PAD_X);
    localparam logic [9:0] L_X1       = 10'(L_PAD_X + PAD_W - 1);
    localparam logic [9:0] R_X0       = 10'(R_PAD_X);
    localparam logic [9:0] R_X1       = 10'(R_PAD_X + PAD_W - 1);
    localparam logic [9:0] NET_X0     = 10'(H_ACTIVE / 2 - 1);
    localparam logic [9:0] NET_X1     = 10'(H_ACTIVE / 2);
    localparam logic signed [9:0] V_POS = 10'(BALL_V);
    localparam logic signed [9:0] V_NEG = -10'(BALL_V);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, MISS, OVER} state_t;

    state_t              state, state_next;
    logic [9:0]          l_top, r_top, ball_x, ball_y;
    logic [9:0]          l_top_next, r_top_next, ball_x_next, ball_y_next;
    logic signed [9:0]   dx, dy, serve_dx, dx_next, dy_next, serve_dx_next;
    logic [SCORE_W-1:0]  score_l_next, score_r_next;
    logic [CNT_W-1:0]    miss_cnt, miss_cnt_next;
    logic                serve_latch, serve_latch_next;
    logic [2:0]          rgb_next;

    function automatic logic [9:0] pad_move(input logic [9:0] top, input logic [1:0] btn);
        case (btn)
            2'b10:   pad_move = (top + PAD_STEP > PAD_MAX) ? PAD_MAX : top + PAD_STEP;
            2'b01:   pad_move = (top < PAD_STEP) ? 10'd0 : top - PAD_STEP;
            default: pad_move = top;
        endcase
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        sat_inc = (s == SCORE_SAT) ? s : s + SCORE_W'(1);
    endfunction

    function automatic logic [7:0] ball_row(input logic [2:0] r);
        case (r)
            3'd0, 3'd7: ball_row = 8'h3C;
            3'd1, 3'd6: ball_row = 8'h7E;
            default:    ball_row = 8'hFF;
        endcase
    endfunction

    logic       tick, mov_r, mov_d, miss_r, miss_l, hit_r, hit_l, bounce_t, bounce_b;
    logic [9:0] bx7, by7;

    assign tick     = (pix_y == TICK_Y) && (pix_x == 10'd0);
    assign bx7      = ball_x + 10'd7;
    assign by7      = ball_y + 10'd7;
    assign mov_r    = dx > 10'sd0;
    assign mov_d    = dy > 10'sd0;
    assign miss_r   = mov_r && (bx7 >= X_MISS_R);
    assign miss_l   = !mov_r && (ball_x <= BV);
    assign hit_r    = mov_r && (bx7 >= R_X0) && (bx7 <= R_X1)
                      && (by7 >= r_top) && (ball_y <= r_top + PAD_H_M1);
    assign hit_l    = !mov_r && (ball_x >= L_X0) && (ball_x <= L_X1)
                      && (by7 >= l_top) && (ball_y <= l_top + PAD_H_M1);
    assign bounce_t = !mov_d && (ball_y <= BV);
    assign bounce_b = mov_d && (by7 >= Y_BOT);
    assign game_over = (state == OVER);

    // Game FSM and all frame-rate state: next values, holding by default.
    always_comb begin
        state_next       = state;
        l_top_next       = l_top;
        r_top_next       = r_top;
        ball_x_next      = ball_x;
        ball_y_next      = ball_y;
        dx_next          = dx;
        dy_next          = dy;
        serve_dx_next    = serve_dx;
        score_l_next     = score_l;
        score_r_next     = score_r;
        miss_cnt_next    = miss_cnt;
        serve_latch_next = serve_latch;
        // Serve requests are only remembered while waiting for one.
        if (serve && (state == IDLE || state == OVER)) serve_latch_next = 1'b1;
        else                                           serve_latch_next = serve_latch;
        if (tick) begin
            if (state == IDLE || state == PLAY) begin
                l_top_next = pad_move(l_top, btn_l);
                r_top_next = pad_move(r_top, btn_r);
            end else begin
                l_top_next = l_top;
                r_top_next = r_top;
            end
            case (state)
                IDLE: begin
                    if (serve_latch) begin
                        state_next       = PLAY;
                        serve_latch_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
                PLAY: begin
                    if (miss_r) begin
                        score_l_next  = sat_inc(score_l);
                        serve_dx_next = V_POS;
                        state_next    = MISS;
                    end else if (miss_l) begin
                        score_r_next  = sat_inc(score_r);
                        serve_dx_next = V_NEG;
                        state_next    = MISS;
                    end else begin
                        if (hit_r)      dx_next = V_NEG;
                        else if (hit_l) dx_next = V_POS;
                        else            dx_next = dx;
                        if (bounce_t)      dy_next = V_POS;
                        else if (bounce_b) dy_next = V_NEG;
                        else               dy_next = dy;
                        ball_x_next = ball_x + $unsigned(dx);
                        ball_y_next = ball_y + $unsigned(dy);
                    end
                end
                MISS: begin
                    if (miss_cnt == CNT_LAST) begin
                        miss_cnt_next = '0;
                        if (score_l == SCORE_MAX || score_r == SCORE_MAX) begin
                            state_next = OVER;
                        end else begin
                            state_next  = IDLE;
                            ball_x_next = BALL_X0;
                            ball_y_next = BALL_Y0;
                            dx_next     = serve_dx;
                            dy_next     = V_POS;
                        end
                    end else begin
                        miss_cnt_next = miss_cnt + CNT_W'(1);
                    end
                end
                OVER: begin
                    if (serve_latch) begin
                        state_next       = IDLE;
                        serve_latch_next = 1'b0;
                        score_l_next     = '0;
                        score_r_next     = '0;
                        ball_x_next      = BALL_X0;
                        ball_y_next      = BALL_Y0;
                        dx_next          = serve_dx;
                        dy_next          = V_POS;
                        l_top_next       = PAD_CTR;
                        r_top_next       = PAD_CTR;
                    end else begin
                        state_next = OVER;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else begin
            state_next = state;
        end
    end

    // Game state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            l_top       <= PAD_CTR;
            r_top       <= PAD_CTR;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            dx          <= V_POS;
            dy          <= V_POS;
            serve_dx    <= V_POS;
            score_l     <= '0;
            score_r     <= '0;
            miss_cnt    <= '0;
            serve_latch <= 1'b0;
        end else begin
            state       <= state_next;
            l_top       <= l_top_next;
            r_top       <= r_top_next;
            ball_x      <= ball_x_next;
            ball_y      <= ball_y_next;
            dx          <= dx_next;
            dy          <= dy_next;
            serve_dx    <= serve_dx_next;
            score_l     <= score_l_next;
            score_r     <= score_r_next;
            miss_cnt    <= miss_cnt_next;
            serve_latch <= serve_latch_next;
        end
    end

    logic       l_pad_on, r_pad_on, ball_box, ball_on, net_on;
    logic [2:0] ball_col, ball_rsel;
    logic [7:0] ball_bits;

    assign l_pad_on  = (pix_x >= L_X0) && (pix_x <= L_X1)
                       && (pix_y >= l_top) && (pix_y <= l_top + PAD_H_M1);
    assign r_pad_on  = (pix_x >= R_X0) && (pix_x <= R_X1)
                       && (pix_y >= r_top) && (pix_y <= r_top + PAD_H_M1);
    assign ball_box  = (pix_x >= ball_x) && (pix_x <= bx7) && (pix_y >= ball_y) && (pix_y <= by7);
    assign ball_col  = 3'(pix_x - ball_x);
    assign ball_rsel = 3'(pix_y - ball_y);
    assign ball_bits = ball_row(ball_rsel);
    assign ball_on   = ball_box && ball_bits[ball_col];
    assign net_on    = (pix_x >= NET_X0) && (pix_x <= NET_X1) && !pix_y[4];

    // Pixel colour selection in draw priority order.
    always_comb begin
        rgb_next = 3'b110;
        if (!video_on)           rgb_next = 3'b000;
        else if (l_pad_on)       rgb_next = 3'b001;
        else if (r_pad_on)       rgb_next = 3'b010;
        else if (ball_on)        rgb_next = 3'b100;
        else if (net_on)         rgb_next = 3'b111;
        else if (state == OVER)  rgb_next = 3'b000;
        else                     rgb_next = 3'b110;
    end

    // Registered colour output.
    always_ff @(posedge clk) begin
        if (reset) graph_rgb <= 3'b000;
        else       graph_rgb <= rgb_next;
    end
endmodule
